// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI mode-0 responder that turns framed SPI transactions into
// single-word register-bus reads and writes. SPI pins are oversampled in clk.
// Frame: ss_n falls, then W bit, addr[AW-1:0], data[DW-1:0], MSB first.
// Ports:
//   clk, rstn                         system clock, async active-low reset
//   spi_sck, spi_ss_n, spi_mosi       SPI inputs (asynchronous to clk)
//   spi_miso                          SPI output, 0 when not shifting read data
//   reg_req, reg_we, reg_addr,
//   reg_wdata, reg_rdata, reg_ack     register-bus request/ack handshake
//   err_abort, err_late               one-cycle error pulses
module spi_reg_slave #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          spi_sck,
  input  logic          spi_ss_n,
  input  logic          spi_mosi,
  output logic          spi_miso,
  output logic          reg_req,
  output logic          reg_we,
  output logic [AW-1:0] reg_addr,
  output logic [DW-1:0] reg_wdata,
  input  logic [DW-1:0] reg_rdata,
  input  logic          reg_ack,
  output logic          err_abort,
  output logic          err_late
);

  localparam int unsigned CW = $clog2(AW + DW + 1);
  localparam logic [CW-1:0] HDR_LAST  = CW'(AW);
  localparam logic [CW-1:0] DATA_LAST = CW'(DW - 1);

  typedef enum logic [2:0] {IDLE, HDR, DATA, WR_REQ, DONE} state_t;
  state_t state, state_nxt;

  logic [1:0]    sck_sync, ss_sync, mosi_sync;
  logic          sck_prev, ss_prev;
  logic          sck_rise, sck_fall, ss_fall, ss_high, mosi_s;
  logic [CW-1:0] bit_cnt;
  logic [AW:0]   hdr_sr, hdr_nxt;
  logic [DW-1:0] data_sr, data_nxt;
  logic          is_wr, rd_got, late, pend, mine;
  logic          frame_start, abort, hdr_shift, hdr_done, data_rise, data_done;
  logic          miso_shift, rd_deadline, rd_issue, wr_issue, capture;

  // Synchronisers; ss_n resets high so no false frame start after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sck_sync  <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
      ss_prev   <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[0], spi_sck};
      ss_sync   <= {ss_sync[0], spi_ss_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sck_prev  <= sck_sync[1];
      ss_prev   <= ss_sync[1];
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_prev;
  assign sck_fall = ~sck_sync[1] & sck_prev;
  assign ss_fall  = ~ss_sync[1] & ss_prev;
  assign ss_high  = ss_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign hdr_nxt  = {hdr_sr[AW-1:0], mosi_s};
  assign data_nxt = {data_sr[DW-2:0], mosi_s};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (frame_start) state_nxt = HDR;
      HDR:     if (abort) state_nxt = IDLE;
               else if (hdr_done) state_nxt = DATA;
      DATA:    if (abort) state_nxt = IDLE;
               else if (data_done) state_nxt = is_wr ? WR_REQ : DONE;
      WR_REQ:  if (reg_req && reg_ack && mine) state_nxt = DONE;
      DONE:    if (ss_high) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state strobes; ss_n high takes priority over any SCK edge.
  always_comb begin
    frame_start = 1'b0;
    abort       = 1'b0;
    hdr_shift   = 1'b0;
    hdr_done    = 1'b0;
    data_rise   = 1'b0;
    data_done   = 1'b0;
    miso_shift  = 1'b0;
    rd_deadline = 1'b0;
    unique case (state)
      IDLE: frame_start = ss_fall;
      HDR: begin
        if (ss_high) abort = 1'b1;
        else if (sck_rise) begin
          hdr_shift = 1'b1;
          hdr_done  = (bit_cnt == HDR_LAST);
        end
      end
      DATA: begin
        if (ss_high) abort = 1'b1;
        else begin
          if (sck_rise) begin
            data_rise = 1'b1;
            data_done = (bit_cnt == DATA_LAST);
          end
          if (sck_fall && !is_wr) begin
            miso_shift  = 1'b1;
            rd_deadline = (bit_cnt == '0);
          end
        end
      end
      default: ;
    endcase
    rd_issue = hdr_done & ~hdr_nxt[AW];
    wr_issue = data_done & is_wr;
    capture  = reg_req & reg_ack & mine & (state == DATA) & ~is_wr &
               ~late & ~rd_got & ~miso_shift;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt   <= '0;
      hdr_sr    <= '0;
      data_sr   <= '0;
      is_wr     <= 1'b0;
      rd_got    <= 1'b0;
      late      <= 1'b0;
      pend      <= 1'b0;
      mine      <= 1'b0;
      spi_miso  <= 1'b0;
      reg_req   <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      err_abort <= 1'b0;
      err_late  <= 1'b0;
    end else begin
      err_abort <= abort;
      err_late  <= rd_deadline & ~rd_got;

      if (frame_start) begin
        bit_cnt <= '0;
        late    <= 1'b0;
        rd_got  <= 1'b0;
      end else if (hdr_shift) begin
        hdr_sr  <= hdr_nxt;
        bit_cnt <= hdr_done ? '0 : bit_cnt + CW'(1);
        if (hdr_done) is_wr <= hdr_nxt[AW];
      end else if (data_rise) begin
        bit_cnt <= bit_cnt + CW'(1);
      end
      if (rd_deadline && !rd_got) late <= 1'b1;

      // One shift register: shifts MOSI in for writes, read data out for reads.
      if (data_rise && is_wr)  data_sr <= data_nxt;
      else if (miso_shift)     data_sr <= {data_sr[DW-2:0], 1'b0};
      else if (capture)        data_sr <= reg_rdata;
      if (capture) rd_got <= 1'b1;

      if (state != DATA || is_wr) spi_miso <= 1'b0;
      else if (miso_shift)        spi_miso <= rd_got & data_sr[DW-1];

      // A request raised while an older one (from an aborted frame) is still
      // outstanding is parked in pend and issued once the bus is free.
      if (reg_req && reg_ack) begin
        reg_req <= 1'b0;
        mine    <= 1'b0;
      end else if (!reg_req && (rd_issue || wr_issue || pend) && !abort) begin
        reg_req  <= 1'b1;
        mine     <= 1'b1;
        pend     <= 1'b0;
        reg_we   <= is_wr & ~rd_issue;
        reg_addr <= rd_issue ? hdr_nxt[AW-1:0] : hdr_sr[AW-1:0];
        if (is_wr && !rd_issue) reg_wdata <= wr_issue ? data_nxt : data_sr;
      end else if (rd_issue || wr_issue) begin
        pend <= 1'b1;
      end
      if (abort || frame_start) begin
        pend <= 1'b0;
        mine <= 1'b0;
      end
      if (data_done && !is_wr) pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: directed bench for spi_reg_slave. A bit-banged SPI master
// drives frames; a small register-file responder acks after a programmable
// delay; a monitor records request and error-pulse history.
module tb_spi_reg_slave;

  localparam int HALF = 100; // half SCK period: 10 clk periods

  logic        clk, rstn;
  logic        spi_sck, spi_ss_n, spi_mosi, spi_miso;
  logic        reg_req, reg_we, reg_ack;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic        err_abort, err_late;

  spi_reg_slave #(.AW(8), .DW(32)) dut (
    .clk(clk), .rstn(rstn),
    .spi_sck(spi_sck), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack),
    .err_abort(err_abort), .err_late(err_late)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned checks = 0, failures = 0;
  int unsigned ack_delay = 1;
  logic [31:0] mem [256];

  // Register-file responder
  int unsigned wait_cnt;
  initial begin
    reg_ack = 1'b0;
    reg_rdata = '0;
    wait_cnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h30] = 32'h1234_5678;
    mem[8'h00] = 32'hCAFE_F00D;
    forever begin
      @(posedge clk); #1;
      if (reg_ack) begin
        reg_ack = 1'b0;
        wait_cnt = 0;
      end else if (reg_req) begin
        wait_cnt++;
        if (wait_cnt > ack_delay) begin
          reg_ack = 1'b1;
          if (reg_we) mem[reg_addr] = reg_wdata;
          else        reg_rdata = mem[reg_addr];
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor
  int unsigned rises = 0, hi_len = 0, late_cnt = 0, abort_cnt = 0;
  logic        req_prev = 1'b0;
  logic        rise_we;
  logic [7:0]  rise_addr;
  logic [31:0] rise_wdata;
  initial begin
    forever begin
      @(negedge clk);
      if (reg_req) begin
        if (!req_prev) begin
          rises++;
          hi_len = 0;
          rise_we = reg_we;
          rise_addr = reg_addr;
          rise_wdata = reg_wdata;
        end
        hi_len++;
      end
      req_prev = reg_req;
      if (err_late)  late_cnt++;
      if (err_abort) abort_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_xfer(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                          input int unsigned nbits, input logic release_ss,
                          output logic [31:0] rdata);
    logic [40:0] frame;
    frame = {we, addr, wdata};
    rdata = '0;
    spi_ss_n = 1'b0;
    #(HALF);
    for (int i = 0; i < int'(nbits); i++) begin
      spi_mosi = frame[40-i];
      #(HALF);
      if (i >= 9) rdata = {rdata[30:0], spi_miso};
      spi_sck = 1'b1;
      #(HALF);
      spi_sck = 1'b0;
    end
    #(HALF);
    if (release_ss) spi_ss_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_miso"},  32'(spi_miso),  32'h0);
    check({tag, "_req"},   32'(reg_req),   32'h0);
    check({tag, "_we"},    32'(reg_we),    32'h0);
    check({tag, "_addr"},  32'(reg_addr),  32'h0);
    check({tag, "_wdata"}, reg_wdata,      32'h0);
    check({tag, "_abort"}, 32'(err_abort), 32'h0);
    check({tag, "_late"},  32'(err_late),  32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    int unsigned b_rises, b_late, b_abort;
    rstn = 1'b0;
    spi_sck = 1'b0;
    spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rstn = 1'b1;
    repeat (5) @(posedge clk);

    // Write 0x04 <- 0x2710, ack after 2 cycles
    ack_delay = 2;
    b_rises = rises; b_late = late_cnt; b_abort = abort_cnt;
    spi_xfer(1'b1, 8'h04, 32'h0000_2710, 41, 1'b1, rd);
    #(4*HALF);
    check("wr_req_count", rises - b_rises, 1);
    check("wr_we", 32'(rise_we), 1);
    check("wr_addr", 32'(rise_addr), 32'h04);
    check("wr_wdata", rise_wdata, 32'h0000_2710);
    check("wr_hi_len", hi_len, 3);
    check("wr_mem", mem[8'h04], 32'h0000_2710);
    check("wr_no_late", late_cnt - b_late, 0);
    check("wr_no_abort", abort_cnt - b_abort, 0);

    // Read 0x30, ack 1 cycle after request
    ack_delay = 1;
    b_rises = rises; b_late = late_cnt;
    spi_xfer(1'b0, 8'h30, 32'h0, 41, 1'b1, rd);
    #(4*HALF);
    check("rd_data", rd, 32'h1234_5678);
    check("rd_req_count", rises - b_rises, 1);
    check("rd_we", 32'(rise_we), 0);
    check("rd_addr", 32'(rise_addr), 32'h30);
    check("rd_hi_len", hi_len, 2);
    check("rd_no_late", late_cnt - b_late, 0);

    // Late read: ack 20 cycles after request
    ack_delay = 20;
    b_rises = rises; b_late = late_cnt;
    spi_xfer(1'b0, 8'h30, 32'h0, 41, 1'b1, rd);
    #(4*HALF);
    check("late_data", rd, 32'h0);
    check("late_pulses", late_cnt - b_late, 1);
    check("late_req_count", rises - b_rises, 1);
    check("late_hi_len", hi_len, 21);
    check("late_req_low", 32'(reg_req), 0);

    // Abort after 20 bits of a write, then a full write and read-back
    ack_delay = 1;
    b_rises = rises; b_abort = abort_cnt;
    spi_xfer(1'b1, 8'h08, 32'h5555_5555, 20, 1'b1, rd);
    #(4*HALF);
    check("abort_pulses", abort_cnt - b_abort, 1);
    check("abort_no_req", rises - b_rises, 0);
    b_rises = rises; b_abort = abort_cnt;
    spi_xfer(1'b1, 8'h08, 32'hA5A5_A5A5, 41, 1'b1, rd);
    #(4*HALF);
    check("post_abort_req_count", rises - b_rises, 1);
    check("post_abort_addr", 32'(rise_addr), 32'h08);
    check("post_abort_wdata", rise_wdata, 32'hA5A5_A5A5);
    check("post_abort_no_abort", abort_cnt - b_abort, 0);
    spi_xfer(1'b0, 8'h08, 32'h0, 41, 1'b1, rd);
    #(4*HALF);
    check("post_abort_readback", rd, 32'hA5A5_A5A5);

    // Reset pulsed during the data phase of a read
    spi_xfer(1'b0, 8'h30, 32'h0, 20, 1'b0, rd);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("midreset");
    spi_ss_n = 1'b1;
    repeat (5) @(posedge clk);
    rstn = 1'b1;
    #(4*HALF);
    spi_xfer(1'b0, 8'h00, 32'h0, 41, 1'b1, rd);
    #(4*HALF);
    check("post_reset_read", rd, 32'hCAFE_F00D);

    // Back-to-back: write 0x04 <- 1, one SCK period gap, read 0x04
    ack_delay = 2;
    spi_xfer(1'b1, 8'h04, 32'h0000_0001, 41, 1'b1, rd);
    #(2*HALF);
    ack_delay = 1;
    spi_xfer(1'b0, 8'h04, 32'h0, 41, 1'b1, rd);
    #(4*HALF);
    check("b2b_read", rd, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_slave.md
# spi_reg_slave

SPI mode-0 responder that turns framed SPI transactions into single-word register-bus reads and writes. It sits between the chip's SPI pins (`spi_sck`, `spi_ss_n`, `spi_mosi`, `spi_miso`) and the register file that holds the FREQ_n, DATA_n, EN_CORDIC and STATUS registers. It is the device-side counterpart of the bench SPI master. All SPI inputs are oversampled in the `clk` domain; no logic is clocked by `spi_sck`.

## Interface
- `AW`, default 8: register address width in bits (byte address).
- `DW`, default 32: register data width in bits.
- `clk`, input, 1: system clock.
- `rstn`, input, 1: reset. Asynchronous assertion, active-low.
- `spi_sck`, input, 1: SPI clock, asynchronous to `clk`, idle low.
- `spi_ss_n`, input, 1: SPI slave select, active-low.
- `spi_mosi`, input, 1: master-to-slave data, MSB first.
- `spi_miso`, output, 1: slave-to-master data. Driven 0 when not selected.
- `reg_req`, output, 1: register access request. Held until acknowledged.
- `reg_we`, output, 1: 1 = write, 0 = read. Valid while `reg_req` is high.
- `reg_addr`, output, AW: register address.
- `reg_wdata`, output, DW: write data.
- `reg_rdata`, input, DW: read data. Sampled in the cycle `reg_ack` is high.
- `reg_ack`, input, 1: access complete. Ignored while `reg_req` is low.
- `err_abort`, output, 1: one-cycle pulse when a frame is aborted.
- `err_late`, output, 1: one-cycle pulse when read data arrives too late.

## Operation
- **Input synchronisation:** 2-flop synchronisers on `spi_sck`, `spi_ss_n` and `spi_mosi`. A rising or falling edge is detected from the synchronised `spi_sck` and its previous value.
- **Frame format:** `spi_ss_n` falls, then 1 + AW + DW bits, MSB first.
  - Header: bit 0 is W (1 = write), followed by `addr[AW-1:0]`.
  - Data: `DW` bits of data.
  - Default frame length is 41 bits.
- **Sampling and driving:** MOSI is sampled on `spi_sck` rising edges. MISO changes on falling edges.
- **State machine:**
  - **IDLE:** on the `spi_ss_n` falling edge, go to HDR and clear the bit counter.
  - **HDR:** shift in header bits. After the last header bit:
    - W=1: go to DATA.
    - W=0: raise `reg_req` with `reg_we`=0 and `reg_addr` loaded, then go to DATA.
  - **DATA:** shift `DW` bits.
    - Reads: shift out from a load register. `rdata` is captured on `reg_ack`.
    - Writes: shift in to `reg_wdata`.
    - After the last bit: a write goes to WR_REQ, a read goes to DONE.
  - **WR_REQ:** raise `reg_req` with `reg_we`=1. On `reg_ack`, go to DONE.
  - **DONE:** ignore further SCK edges and hold `spi_miso` at 0. Go to IDLE on `spi_ss_n` high.
- **Read deadline:** the first falling edge after the header. If `reg_ack` has not been seen by then:
  - pulse `err_late`;
  - shift zeros for the whole data phase;
  - a later `rdata` is discarded.
- **Handshake:** `reg_req`, `reg_we`, `reg_addr` and `reg_wdata` are stable from the rise of `reg_req` until `reg_ack` is sampled. `reg_req` is low in the cycle after the ack. A same-cycle (zero-wait) ack is legal. At most one access is outstanding.
- **Abort:** `spi_ss_n` rises before the frame completes (HDR or DATA).
  - Pulse `err_abort` and return to IDLE.
  - No write request is issued.
  - An outstanding read request stays asserted until acked; its data is dropped.
  - A new frame may start, but its request waits until the old one is acked.
- **Reset:** `rstn` low mid-frame forces IDLE immediately.

## Timing
- **Reset values:** `spi_miso`=0, `reg_req`=0, `reg_we`=0, `reg_addr`=0, `reg_wdata`=0, `err_abort`=0, `err_late`=0.
- **Minimum SCK period:** 8 `clk` periods. The high and low phases are each at least 4 `clk`.
- **Edge detection latency:** an SCK edge is detected 3 `clk` cycles after the pin edge (2 sync stages plus the edge register).
- **Read request timing:** `reg_req` for a read rises 1 cycle after the last header rising edge is detected.
- **Read ack budget:** the register file must ack within (half SCK period − 4) `clk` cycles. With the default 20:1 clock ratio this is 6 cycles.
- **MISO update:** `spi_miso` updates 1 cycle after a falling edge is detected.
- **Write request timing:** `reg_req` for a write rises 1 cycle after the last data rising edge is detected.
- **`spi_ss_n` and SCK edge in the same cycle:** `spi_ss_n` has priority.

## Test plan
- **Write:** frame W=1, addr 0x04, data 0x0000_2710, ack after 2 cycles. Required: exactly one `reg_req` with `reg_we`=1, addr 0x04, wdata 0x0000_2710; no error pulses.
- **Read, on time:** frame W=0, addr 0x30; `reg_rdata`=0x1234_5678 acked 1 cycle after `reg_req`. Required: master receives 0x1234_5678; `reg_req` high for 2 cycles.
- **Read, late:** ack delayed 20 cycles. Required: `err_late` pulses once, master receives 0x0000_0000, `reg_req` drops after the ack.
- **Abort:** `spi_ss_n` raised after 20 bits of a write frame. Required: `err_abort` pulses, no `reg_req`, next frame (write 0x08 ← 0xA5A5_A5A5) completes correctly.
- **Reset mid-frame:** `rstn` pulsed low during the data phase of a read. Required: all outputs at reset values; the following read of 0x00 returns correct data.
- **Back-to-back:** write 0x04 ← 1, then read 0x04 with `spi_ss_n` high for 1 SCK period between frames. Required: the read returns 0x0000_0001.
